uio_bus_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares the tile's 8-bit bidirectional uio bus among NREQ internal requesters.
- Grants the bus to one owner at a time and inserts a bus turnaround (uio_oe all-zero) between owners.
- Bounds each tenure with a burst limit.
- Sits between the internal engines and the top-level uio_out/uio_oe pins.

---
 rtl/uio_bus_arbiter.sv | 171 +++++++++++++++++
 tb/tb_uio_bus_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uio_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uio_bus_arbiter
// Purpose  : Round-robin owner sequencer for the shared 8-bit uio bus, with
//            an undriven turnaround before each tenure and a burst limit.
// Revision : 1.0 - initial release
// ============================================================================
module uio_bus_arbiter #(
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 8,
    parameter int TURN_CYC  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   last,
    input  logic [NREQ*8-1:0] dout,
    input  logic [NREQ*8-1:0] doe,
    output logic [NREQ-1:0]   grant,
    output logic [7:0]        uio_out,
    output logic [7:0]        uio_oe,
    output logic              busy
);

    localparam int c_idx_w = $clog2(NREQ);
    localparam int c_bw    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int c_tw    = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

    localparam logic [c_bw-1:0]    c_burst_last = c_bw'(MAX_BURST - 1);
    localparam logic [c_tw-1:0]    c_turn_last  = c_tw'(TURN_CYC - 1);
    localparam logic [c_idx_w-1:0] c_idx_last   = c_idx_w'(NREQ - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TURN = 2'd1,
        S_OWN  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_idx_w-1:0]  r_owner;
    logic [c_idx_w-1:0]  w_owner_nxt;
    logic [c_idx_w-1:0]  r_ptr;
    logic [c_idx_w-1:0]  w_ptr_nxt;
    logic [c_bw-1:0]     r_burst;
    logic [c_bw-1:0]     w_burst_nxt;
    logic [c_tw-1:0]     r_turn;
    logic [c_tw-1:0]     w_turn_nxt;
    logic [NREQ-1:0]     r_grant;
    logic [NREQ-1:0]     w_grant_nxt;

    logic [c_idx_w-1:0]  w_cand [NREQ];
    logic [c_idx_w-1:0]  w_win;
    logic [c_idx_w-1:0]  w_win_inc;
    logic [NREQ-1:0]     w_owner_oh;
    logic                w_any;
    logic                w_others;
    logic                w_own_req;
    logic                w_own_last;
    logic                w_burst_end;
    logic                w_release;

    // Candidate k is the requester k places above the round-robin pointer.
    for (genvar k = 0; k < NREQ; k++) begin : g_cand
        assign w_cand[k] = c_idx_w'((int'(r_ptr) + k) % NREQ);
    end

    for (genvar i = 0; i < NREQ; i++) begin : g_owner_oh
        assign w_owner_oh[i] = (r_owner == c_idx_w'(i));
    end

    // Scanning from the far end lets the nearest requester overwrite the rest.
    always_comb begin
        w_win = r_ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[w_cand[k]]) begin
                w_win = w_cand[k];
            end
        end
    end

    assign w_win_inc   = (w_win == c_idx_last) ? '0 : w_win + 1'b1;
    assign w_any       = |req;
    assign w_others    = |(req & ~w_owner_oh);
    assign w_own_req   = req[r_owner];
    assign w_own_last  = last[r_owner];
    assign w_burst_end = (r_burst == c_burst_last);
    assign w_release   = !ena || !w_own_req || w_own_last || (w_burst_end && w_others);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
            r_burst <= '0;
            r_turn  <= '0;
            r_grant <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_burst <= w_burst_nxt;
            r_turn  <= w_turn_nxt;
            r_grant <= w_grant_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_burst_nxt = r_burst;
        w_turn_nxt  = r_turn;
        w_grant_nxt = r_grant;
        case (r_state)
            S_IDLE: begin
                w_grant_nxt = '0;
                if (ena && w_any) begin
                    w_state_nxt = S_TURN;
                    w_owner_nxt = w_win;
                    w_ptr_nxt   = w_win_inc;
                    w_turn_nxt  = '0;
                end
            end
            S_TURN: begin
                w_grant_nxt = '0;
                if (!ena) begin
                    w_state_nxt = S_IDLE;
                end else if (r_turn == c_turn_last) begin
                    w_state_nxt = S_OWN;
                    w_grant_nxt = w_owner_oh;
                    w_burst_nxt = '0;
                end else begin
                    w_turn_nxt = r_turn + 1'b1;
                end
            end
            S_OWN: begin
                if (w_release) begin
                    w_state_nxt = S_IDLE;
                    w_grant_nxt = '0;
                end else if (w_burst_end) begin
                    // Uncontended owner keeps the bus; only the counter wraps.
                    w_burst_nxt = '0;
                end else begin
                    w_burst_nxt = r_burst + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // The bus mux follows registered state, so the owner still drives during
    // the cycle in which its release condition is seen.
    always_comb begin
        uio_out = '0;
        uio_oe  = '0;
        if (r_state == S_OWN) begin
            uio_out = dout[{r_owner, 3'b000} +: 8];
            uio_oe  = doe[{r_owner, 3'b000} +: 8];
        end
    end

    assign grant = r_grant;
    assign busy  = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uio_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uio_bus_arbiter
// Purpose  : Scoreboard bench for uio_bus_arbiter (NREQ=4, MAX_BURST=8, TURN_CYC=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uio_bus_arbiter;

    localparam int NREQ      = 4;
    localparam int MAX_BURST = 8;
    localparam int TURN_CYC  = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              ena;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   last;
    logic [NREQ*8-1:0] dout;
    logic [NREQ*8-1:0] doe;
    logic [NREQ-1:0]   grant;
    logic [7:0]        uio_out;
    logic [7:0]        uio_oe;
    logic              busy;

    typedef struct {
        string          tag;
        logic           busy;
        logic [NREQ-1:0] grant;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    uio_bus_arbiter #(
        .NREQ      (NREQ),
        .MAX_BURST (MAX_BURST),
        .TURN_CYC  (TURN_CYC)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .req     (req),
        .last    (last),
        .dout    (dout),
        .doe     (doe),
        .grant   (grant),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] dat_of(input int i);
        return 8'hC0 | 8'(i);
    endfunction

    function automatic logic [7:0] oe_of(input int i);
        return 8'(17 * (i + 1));
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_bus(input exp_t e);
        logic [7:0] eo;
        logic [7:0] ee;
        eo = '0;
        ee = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (e.grant[i]) begin
                eo = dat_of(i);
                ee = oe_of(i);
            end
        end
        check({e.tag, "_grant"}, 32'(grant), 32'(e.grant));
        check({e.tag, "_busy"}, 32'(busy), 32'(e.busy));
        check({e.tag, "_out"}, 32'(uio_out), 32'(eo));
        check({e.tag, "_oe"}, 32'(uio_oe), 32'(ee));
    endtask

    // Push the expectation for the coming edge, then let the monitor judge it.
    task automatic cyc(input string tag, input logic b, input logic [NREQ-1:0] g);
        exp_t e;
        e.tag   = tag;
        e.busy  = b;
        e.grant = g;
        sb_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        #1 check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                check_bus(mon_e);
            end
        end
    end

    initial begin
        rst  = 1'b1;
        ena  = 1'b0;
        req  = '0;
        last = '0;
        for (int i = 0; i < NREQ; i++) begin
            dout[i*8 +: 8] = dat_of(i);
            doe[i*8 +: 8]  = oe_of(i);
        end
        #2;
        check("reset_grant", 32'(grant), 32'd0);
        check("reset_out", 32'(uio_out), 32'd0);
        check("reset_oe", 32'(uio_oe), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ena = 1'b1;

        // Single requester
        req = 4'b0001;
        cyc("t1_turn", 1'b1, 4'b0000);
        cyc("t1_own", 1'b1, 4'b0001);
        repeat (3) cyc("t1_hold", 1'b1, 4'b0001);
        req = 4'b0000;
        cyc("t1_rel", 1'b0, 4'b0000);
        cyc("t1_idle", 1'b0, 4'b0000);

        // Round robin with last on the third OWN cycle
        do_reset();
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            logic [NREQ-1:0] oh;
            oh = 4'b0001 << (t % NREQ);
            cyc("t2_turn", 1'b1, 4'b0000);
            cyc("t2_own1", 1'b1, oh);
            cyc("t2_own2", 1'b1, oh);
            cyc("t2_own3", 1'b1, oh);
            last = oh;
            cyc("t2_rel", 1'b0, 4'b0000);
            last = 4'b0000;
        end
        req = 4'b0000;
        cyc("t2_idle", 1'b0, 4'b0000);

        // Burst preempt under contention, then uncontended wrap
        do_reset();
        req = 4'b0011;
        cyc("t3_turn0", 1'b1, 4'b0000);
        repeat (MAX_BURST) cyc("t3_own0", 1'b1, 4'b0001);
        cyc("t3_preempt", 1'b0, 4'b0000);
        cyc("t3_turn1", 1'b1, 4'b0000);
        cyc("t3_own1", 1'b1, 4'b0010);
        req = 4'b0001;
        cyc("t3_rel1", 1'b0, 4'b0000);
        cyc("t3_turn_solo", 1'b1, 4'b0000);
        repeat (3 * MAX_BURST) cyc("t3_solo", 1'b1, 4'b0001);
        req = 4'b0000;
        cyc("t3_rel_solo", 1'b0, 4'b0000);

        // ena drop during OWN of requester 2
        req = 4'b0100;
        cyc("t4_turn", 1'b1, 4'b0000);
        cyc("t4_own", 1'b1, 4'b0100);
        cyc("t4_own2", 1'b1, 4'b0100);
        ena = 1'b0;
        #1;
        check("t4_final_oe", 32'(uio_oe), 32'(oe_of(2)));
        check("t4_final_out", 32'(uio_out), 32'(dat_of(2)));
        cyc("t4_rel", 1'b0, 4'b0000);
        repeat (3) cyc("t4_hold", 1'b0, 4'b0000);
        ena = 1'b1;
        cyc("t4_turn2", 1'b1, 4'b0000);
        cyc("t4_regrant", 1'b1, 4'b0100);

        // Async reset mid-OWN, no clock edge in between
        #1 rst = 1'b1;
        #1;
        check("t5_grant", 32'(grant), 32'd0);
        check("t5_out", 32'(uio_out), 32'd0);
        check("t5_oe", 32'(uio_oe), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        #1 rst = 1'b0;
        req = 4'b1111;
        cyc("t5_turn", 1'b1, 4'b0000);
        cyc("t5_own0", 1'b1, 4'b0001);
        req = 4'b0000;
        cyc("t5_rel", 1'b0, 4'b0000);

        // Late drop during TURN still yields exactly one OWN cycle
        req = 4'b0010;
        cyc("t6_turn", 1'b1, 4'b0000);
        req = 4'b0000;
        cyc("t6_own", 1'b1, 4'b0010);
        cyc("t6_rel", 1'b0, 4'b0000);
        req = 4'b1111;
        cyc("t6_ptr_turn", 1'b1, 4'b0000);
        cyc("t6_ptr_own", 1'b1, 4'b0100);
        req = 4'b0000;
        cyc("t6_idle", 1'b0, 4'b0000);

        @(posedge clk);
        #3;
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
